// File: rtl/multibyte_add_pkg.sv
// Shared types and helpers for the multi-byte add sequencer.
// Operands wider than MAX_LIMBS limbs are not supported by get_limb.
package multibyte_add_pkg;

  localparam int LIMB_W     = 8;
  localparam int MAX_LIMBS  = 64;
  localparam int LIMB_VEC_W = LIMB_W * MAX_LIMBS;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStrobe,
    StWaitBusy,
    StWaitDone,
    StCapture,
    StOut
  } seq_state_t;

  // Callers zero-extend their operand to LIMB_VEC_W before passing it in.
  function automatic logic [LIMB_W-1:0] get_limb(input logic [LIMB_VEC_W-1:0] vec,
                                                 input int unsigned idx);
    return LIMB_W'(vec >> (idx * LIMB_W));
  endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Shared between the LOAD hold count and the adder handshake timeouts.
module seq_timeout_ctr #(
  parameter int unsigned Width = 6
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/multibyte_add_seq.sv
// Sequences a BYTES-wide addition through an external 8-bit adder, LSB limb first,
// chaining the carry and assembling sum, carry, zero and error flags.
module multibyte_add_seq
  import multibyte_add_pkg::*;
#(
  parameter int unsigned BYTES       = 4,
  parameter int unsigned LOAD_CYCLES = 3,
  parameter int unsigned TIMEOUT     = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [8*BYTES-1:0]    s_a,
  input  logic [8*BYTES-1:0]    s_b,
  input  logic                  s_carry,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [8*BYTES-1:0]    m_sum,
  output logic                  m_carry,
  output logic                  m_zero,
  output logic                  m_err,
  output logic                  add_enable,
  output logic                  add_write,
  output logic                  add_strobe,
  output logic                  add_carry,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  input  logic [7:0]            add_sum,
  input  logic                  add_carry_o,
  input  logic                  add_ready
);

  localparam int unsigned W      = LIMB_W * BYTES;
  localparam int unsigned IdxW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned CntMax = (LOAD_CYCLES > TIMEOUT) ? LOAD_CYCLES : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [IdxW-1:0] LastIdx  = IdxW'(BYTES - 1);
  localparam logic [CntW-1:0] LoadInit = CntW'(LOAD_CYCLES - 1);
  localparam logic [CntW-1:0] WaitInit = CntW'(TIMEOUT - 1);

  seq_state_t      state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            cap_wait_q, cap_wait_d;
  logic            en_q;

  logic            ctr_load, ctr_dec, ctr_expired;
  logic [CntW-1:0] ctr_val;

  seq_timeout_ctr #(
    .Width(CntW)
  ) u_ctr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (ctr_load),
    .load_val(ctr_val),
    .dec     (ctr_dec),
    .expired (ctr_expired)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      cap_wait_q <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      cap_wait_q <= cap_wait_d;
      en_q       <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    err_d      = err_q;
    idx_d      = idx_q;
    cap_wait_d = cap_wait_q;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    ctr_val    = LoadInit;

    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          a_d      = s_a;
          b_d      = s_b;
          carry_d  = s_carry;
          idx_d    = '0;
          zero_d   = 1'b1;
          err_d    = 1'b0;
          ctr_load = 1'b1;
          ctr_val  = LoadInit;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (ctr_expired) state_d = StStrobe;
        else ctr_dec = 1'b1;
      end
      StStrobe: begin
        ctr_load = 1'b1;
        ctr_val  = WaitInit;
        state_d  = StWaitBusy;
      end
      StWaitBusy: begin
        if (!add_ready) begin
          ctr_load = 1'b1;
          ctr_val  = WaitInit;
          state_d  = StWaitDone;
        end else if (ctr_expired) begin
          err_d   = 1'b1;
          state_d = StOut;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      StWaitDone: begin
        if (add_ready) begin
          cap_wait_d = 1'b1;
          state_d    = StCapture;
        end else if (ctr_expired) begin
          err_d   = 1'b1;
          state_d = StOut;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      StCapture: begin
        // First cycle lets the adder's registered sum settle; second cycle stores it.
        if (cap_wait_q) begin
          cap_wait_d = 1'b0;
        end else begin
          sum_d[idx_q*LIMB_W +: LIMB_W] = add_sum;
          carry_d = add_carry_o;
          zero_d  = zero_q & (add_sum == '0);
          if (idx_q == LastIdx) begin
            state_d = StOut;
          end else begin
            idx_d    = idx_q + 1'b1;
            ctr_load = 1'b1;
            ctr_val  = LoadInit;
            state_d  = StLoad;
          end
        end
      end
      StOut: begin
        if (m_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign s_ready    = (state_q == StIdle);
  assign m_valid    = (state_q == StOut);
  assign m_sum      = sum_q;
  assign m_carry    = carry_q;
  assign m_zero     = zero_q;
  assign m_err      = err_q;
  assign add_enable = en_q;
  assign add_write  = (state_q == StLoad) || (state_q == StStrobe) ||
                      (state_q == StWaitBusy) || (state_q == StWaitDone);
  assign add_strobe = (state_q == StStrobe);
  assign add_carry  = carry_q;
  assign add_a      = get_limb(LIMB_VEC_W'(a_q), 32'(idx_q));
  assign add_b      = get_limb(LIMB_VEC_W'(b_q), 32'(idx_q));

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Upstream sequencer for the 8-bit ripple-carry adder stage `carryadder8`.
- Accepts a BYTES-wide operand pair over a valid/ready handshake.
- Drives the adder's enable/write/strobe control one byte at a time, LSB first, chaining carry-out into the next byte's carry-in.
- Assembles the wide sum, carry and zero flags and presents them on a valid/ready output.

Parameters:
- BYTES, 4, number of 8-bit limbs per operand (>=1).
- LOAD_CYCLES, 3, cycles add_write is held high with stable addends before strobe (covers adder input synchronisers).
- TIMEOUT, 32, max cycles to wait for each add_ready edge before flagging error.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- s_valid  in  1  operand pair valid
- s_ready  out  1  sequencer can accept operands
- s_a  in  8*BYTES  addend A
- s_b  in  8*BYTES  addend B
- s_carry  in  1  carry into byte 0
- m_valid  out  1  result valid
- m_ready  in  1  consumer accepts result
- m_sum  out  8*BYTES  A+B+carry, modulo 2^(8*BYTES)
- m_carry  out  1  carry out of top byte
- m_zero  out  1  m_sum == 0
- m_err  out  1  adder handshake timed out; m_sum/m_carry are don't-care
- add_enable  out  1  to adder enable
- add_write  out  1  to adder write
- add_strobe  out  1  to adder strobe
- add_carry  out  1  to adder carry-flag input
- add_a  out  8  to adder addend 0
- add_b  out  8  to adder addend 1
- add_sum  in  8  from adder sum
- add_carry_o  in  1  from adder carry-flag output
- add_ready  in  1  from adder ready

Behaviour:
- Reset values:
  - all outputs 0, except s_ready=1.
  - FSM in IDLE; byte index 0.
  - Reset mid-operation aborts the transaction; no result is emitted.
- add_enable is registered and goes to 1 on the first aclk after reset release, then stays 1.
- FSM states: IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_DONE, CAPTURE, OUT.
- IDLE:
  - s_ready=1.
  - On s_valid&s_ready: latch s_a, s_b, s_carry; clear idx, zero accumulator (=1) and err; go to LOAD.
- LOAD:
  - add_a/add_b = limb[idx]; add_carry = running carry; add_write=1.
  - Held LOAD_CYCLES cycles via counter, then go to STROBE.
  - add_a, add_b and add_carry stay stable from LOAD until leaving CAPTURE.
- STROBE:
  - add_strobe=1 for exactly one cycle; go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for add_ready=0, then go to WAIT_DONE.
- WAIT_DONE:
  - Wait for add_ready=1, then go to CAPTURE.
- Timeout: either wait state exceeding TIMEOUT cycles sets err and jumps to OUT.
- CAPTURE:
  - Wait one cycle for the adder's registered sum, then store add_sum into sum[idx] and add_carry_o into the running carry.
  - zero accumulator &= (add_sum==0).
  - If idx==BYTES-1, go to OUT; else idx++ and go to LOAD.
  - add_write is dropped to 0 in CAPTURE.
- OUT:
  - m_valid=1 with m_sum, m_carry, m_zero, m_err held stable until m_valid&m_ready, then go to IDLE.
  - s_ready=0 throughout every non-IDLE state.
- Arithmetic: unsigned only. Overflow appears only in m_carry; the sum wraps modulo 2^(8*BYTES).
- m_zero is computed from captured bytes, independent of m_carry.
- Latency is not cycle-exact (it depends on the adder). Bound: s handshake to m_valid <= BYTES*(LOAD_CYCLES+8)+2 cycles when the adder is healthy.
- Simultaneous events:
  - m_ready asserted in the same cycle m_valid rises is accepted on that edge.
  - A new s_valid is only accepted back in IDLE, i.e. no overlap with OUT.

Decomposition:
- Package multibyte_add_pkg holds:
  - the state enum typedef (seq_state_t);
  - the limb width constant LIMB_W=8;
  - a function extracting limb i from a packed vector.
- One sub-module, seq_timeout_ctr: loadable down-counter with an expired output, reused for the LOAD hold count and the wait timeouts.
- The adder instance itself is not inside this block; the two are connected at the level above.

Test Plan:
- Bench connects a real carryadder8 and uses BYTES=4.
- 0x000000FF + 0x00000001, carry 0 -> m_sum=0x00000100, m_carry=0, m_zero=0, m_err=0.
- 0xFFFFFFFF + 0x00000001, carry 0 -> m_sum=0x00000000, m_carry=1, m_zero=1.
- 0x12345678 + 0x11111111, carry 1 -> m_sum=0x2345678A, m_carry=0; m_valid within bound.
- Backpressure: hold m_ready=0 for 5 cycles after m_valid. Outputs stay stable and s_ready=0; the result is accepted on the cycle m_ready=1, and s_ready=1 next cycle.
- Reset mid-operation: pulse aresetn low during the byte-2 WAIT_DONE state. All outputs return to reset values immediately and no m_valid appears. The next transaction 0x1+0x1 gives 0x2.
- Replace the adder with a stub holding add_ready=1 -> after TIMEOUT cycles, m_valid=1 and m_err=1.
